// File: rtl/rv_mem_arbiter_if.sv
// RV memory bus bundle: one request/response channel of the 32-bit RV
// memory port. The requester side drives valid/addr/wdata/wstrb and the
// memory side answers with a one-cycle ready pulse and read data.
interface rv_mem_arbiter_if #(
  parameter int AW = 23
);
  logic          valid;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          ready;
  logic [31:0]   rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Three-way arbiter for the shared RV memory port in front of the SDRAM
// controller. Requester 0 (flash loader) always wins; requesters 1 (CPU)
// and 2 (savestate/DMA) either alternate on a tie or use fixed priority.
// Only one transaction is in flight; the grant is held until the SDRAM
// completes, then the winner sees a single-cycle ready with its read data.
module rv_mem_arbiter #(
  parameter int AW = 23,
  parameter bit RR = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ram_busy,
  rv_mem_arbiter_if.slave  m0,
  rv_mem_arbiter_if.slave  m1,
  rv_mem_arbiter_if.slave  m2,
  rv_mem_arbiter_if.master rv,
  output logic [2:0]       grant
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic          rv_valid_q;
  logic [AW-1:0] rv_addr_q;
  logic [31:0]   rv_wdata_q;
  logic [3:0]    rv_wstrb_q;
  logic [2:0]    ready_q;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;
  logic [31:0]   rdata2_q;
  logic          last2_q;

  logic [2:0]    win;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;

  // Pick the one-hot winner among the currently valid requesters.
  always_comb begin
    win = 3'b000;
    if (m0.valid) begin
      win = 3'b001;
    end else if (m1.valid && m2.valid) begin
      win = (RR && !last2_q) ? 3'b100 : 3'b010;
    end else if (m1.valid) begin
      win = 3'b010;
    end else if (m2.valid) begin
      win = 3'b100;
    end
  end

  // Route the winner's request fields toward the downstream registers.
  always_comb begin
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    sel_wstrb = m0.wstrb;
    case (win)
      3'b010: begin
        sel_addr  = m1.addr;
        sel_wdata = m1.wdata;
        sel_wstrb = m1.wstrb;
      end
      3'b100: begin
        sel_addr  = m2.addr;
        sel_wdata = m2.wdata;
        sel_wstrb = m2.wstrb;
      end
      default: begin
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        sel_wstrb = m0.wstrb;
      end
    endcase
  end

  // Transaction FSM: latch a winner, wait for the SDRAM, pulse ready once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rv_valid_q <= 1'b0;
      rv_addr_q  <= '0;
      rv_wdata_q <= '0;
      rv_wstrb_q <= '0;
      grant      <= 3'b000;
      ready_q    <= 3'b000;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      last2_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!ram_busy && (win != 3'b000)) begin
            rv_valid_q <= 1'b1;
            rv_addr_q  <= sel_addr;
            rv_wdata_q <= sel_wdata;
            rv_wstrb_q <= sel_wstrb;
            grant      <= win;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (rv.ready) begin
            rv_valid_q <= 1'b0;
            grant      <= 3'b000;
            ready_q    <= grant;
            if (grant[0]) rdata0_q <= rv.rdata;
            if (grant[1]) rdata1_q <= rv.rdata;
            if (grant[2]) rdata2_q <= rv.rdata;
            if (grant[1]) last2_q <= 1'b0;
            if (grant[2]) last2_q <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          ready_q <= 3'b000;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rv.valid = rv_valid_q;
  assign rv.addr  = rv_addr_q;
  assign rv.wdata = rv_wdata_q;
  assign rv.wstrb = rv_wstrb_q;

  assign m0.ready = ready_q[0];
  assign m1.ready = ready_q[1];
  assign m2.ready = ready_q[2];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;
  assign m2.rdata = rdata2_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: a round-robin instance is checked with a
// vector table, directed corner-case sequences and a randomized run
// against a transaction-level reference model. A fixed-priority instance
// shares the same inputs and is checked on the continuous-contention case.
module tb_rv_mem_arbiter;
  localparam int AW = 23;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ram_busy;
  logic [2:0] grant;
  logic [2:0] f_grant;

  int n_cmp = 0;
  int n_err = 0;

  rv_mem_arbiter_if #(.AW(AW)) m0_if ();
  rv_mem_arbiter_if #(.AW(AW)) m1_if ();
  rv_mem_arbiter_if #(.AW(AW)) m2_if ();
  rv_mem_arbiter_if #(.AW(AW)) rv_if ();
  rv_mem_arbiter_if #(.AW(AW)) f0_if ();
  rv_mem_arbiter_if #(.AW(AW)) f1_if ();
  rv_mem_arbiter_if #(.AW(AW)) f2_if ();
  rv_mem_arbiter_if #(.AW(AW)) frv_if ();

  // 10-unit system clock
  always #5 clk = ~clk;

  rv_mem_arbiter #(.AW(AW), .RR(1'b1)) dut (
    .clk(clk), .resetn(resetn), .ram_busy(ram_busy),
    .m0(m0_if), .m1(m1_if), .m2(m2_if), .rv(rv_if), .grant(grant)
  );

  rv_mem_arbiter #(.AW(AW), .RR(1'b0)) dut_fp (
    .clk(clk), .resetn(resetn), .ram_busy(ram_busy),
    .m0(f0_if), .m1(f1_if), .m2(f2_if), .rv(frv_if), .grant(f_grant)
  );

  // The fixed-priority instance mirrors every input of the main instance
  assign f0_if.valid  = m0_if.valid;
  assign f0_if.addr   = m0_if.addr;
  assign f0_if.wdata  = m0_if.wdata;
  assign f0_if.wstrb  = m0_if.wstrb;
  assign f1_if.valid  = m1_if.valid;
  assign f1_if.addr   = m1_if.addr;
  assign f1_if.wdata  = m1_if.wdata;
  assign f1_if.wstrb  = m1_if.wstrb;
  assign f2_if.valid  = m2_if.valid;
  assign f2_if.addr   = m2_if.addr;
  assign f2_if.wdata  = m2_if.wdata;
  assign f2_if.wstrb  = m2_if.wstrb;
  assign frv_if.ready = rv_if.ready;
  assign frv_if.rdata = rv_if.rdata;

  typedef struct {
    logic [2:0]  valid;
    logic        busy;
    logic [31:0] rdata;
    logic [2:0]  exp_grant;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic v, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    case (n)
      0: begin m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s; end
      1: begin m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s; end
      default: begin m2_if.valid = v; m2_if.addr = a; m2_if.wdata = d; m2_if.wstrb = s; end
    endcase
  endtask

  function automatic logic [AW-1:0] reqAddr(input int n);
    return AW'(32'h1000 * (n + 1));
  endfunction

  function automatic logic [31:0] reqData(input int n);
    return 32'hA000_0000 + 32'(n);
  endfunction

  function automatic logic [2:0] readyVec();
    return {m2_if.ready, m1_if.ready, m0_if.ready};
  endfunction

  function automatic logic [31:0] rdataOf(input int n);
    case (n)
      0: return m0_if.rdata;
      1: return m1_if.rdata;
      default: return m2_if.rdata;
    endcase
  endfunction

  function automatic int oneHotIdx(input logic [2:0] g);
    if (g[0]) return 0;
    if (g[1]) return 1;
    return 2;
  endfunction

  task automatic setValids(input logic [2:0] v);
    for (int n = 0; n < 3; n++) applyStimulus(n, v[n], reqAddr(n), reqData(n), 4'(n));
  endtask

  task automatic doReset();
    resetn = 1'b0;
    ram_busy = 1'b0;
    for (int n = 0; n < 3; n++) applyStimulus(n, 1'b0, '0, '0, '0);
    rv_if.ready = 1'b0;
    rv_if.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  // Reset values on every output
  task automatic testReset();
    doReset();
    checkOutput("rst rv_valid", 32'(rv_if.valid), 0);
    checkOutput("rst grant", 32'(grant), 0);
    checkOutput("rst ready", 32'(readyVec()), 0);
    checkOutput("rst rv_addr", 32'(rv_if.addr), 0);
    checkOutput("rst rv_wdata", rv_if.wdata, 0);
    checkOutput("rst rv_wstrb", 32'(rv_if.wstrb), 0);
    for (int n = 0; n < 3; n++) checkOutput($sformatf("rst m%0d_rdata", n), rdataOf(n), 0);
  endtask

  // Arbitration decisions from a fresh reset, one transaction per record
  task automatic testTable();
    doReset();
    for (int i = 0; i < 12; i++) begin
      setValids(vecs[i].valid);
      ram_busy = vecs[i].busy;
      step();
      checkOutput($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      if (vecs[i].exp_grant != 3'b000) begin
        checkOutput($sformatf("vec%0d rv_addr", i), 32'(rv_if.addr), 32'(reqAddr(oneHotIdx(vecs[i].exp_grant))));
        rv_if.ready = 1'b1;
        rv_if.rdata = vecs[i].rdata;
        step();
        rv_if.ready = 1'b0;
        checkOutput($sformatf("vec%0d ready", i), 32'(readyVec()), 32'(vecs[i].exp_grant));
        checkOutput($sformatf("vec%0d rdata", i), rdataOf(oneHotIdx(vecs[i].exp_grant)), vecs[i].rdata);
        setValids(3'b000);
        step();
        checkOutput($sformatf("vec%0d ready clr", i), 32'(readyVec()), 0);
      end else begin
        repeat (3) step();
        checkOutput($sformatf("vec%0d held grant", i), 32'(grant), 0);
        setValids(3'b000);
        ram_busy = 1'b0;
        step();
        checkOutput($sformatf("vec%0d rv_valid", i), 32'(rv_if.valid), 0);
      end
    end
  endtask

  // ram_busy blocks the grant; release starts the access next cycle
  task automatic testRamBusy();
    doReset();
    ram_busy = 1'b1;
    applyStimulus(1, 1'b1, 23'h01_2340, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput($sformatf("busy rv_valid c%0d", i), 32'(rv_if.valid), 0);
    end
    ram_busy = 1'b0;
    step();
    checkOutput("busy release rv_valid", 32'(rv_if.valid), 1);
    checkOutput("busy release rv_addr", 32'(rv_if.addr), 32'h01_2340);
    rv_if.ready = 1'b1;
    step();
    rv_if.ready = 1'b0;
    applyStimulus(1, 1'b0, '0, '0, '0);
    step();
  endtask

  // Basic read with a single-cycle rv_ready
  task automatic testRead();
    doReset();
    applyStimulus(1, 1'b1, 23'h00_0100, 32'h0, 4'h0);
    step();
    checkOutput("read grant", 32'(grant), 32'b010);
    checkOutput("read rv_addr", 32'(rv_if.addr), 32'h100);
    checkOutput("read rv_wstrb", 32'(rv_if.wstrb), 0);
    step();
    checkOutput("read grant hold", 32'(grant), 32'b010);
    checkOutput("read no early ready", 32'(readyVec()), 0);
    rv_if.ready = 1'b1;
    rv_if.rdata = 32'hDEAD_BEEF;
    step();
    rv_if.ready = 1'b0;
    rv_if.rdata = 32'h1234_5678;
    checkOutput("read ready", 32'(readyVec()), 32'b010);
    checkOutput("read rdata", m1_if.rdata, 32'hDEAD_BEEF);
    checkOutput("read grant clr", 32'(grant), 0);
    checkOutput("read rv_valid clr", 32'(rv_if.valid), 0);
    applyStimulus(1, 1'b0, '0, '0, '0);
    step();
    checkOutput("read ready pulse", 32'(readyVec()), 0);
    checkOutput("read rdata held", m1_if.rdata, 32'hDEAD_BEEF);
  endtask

  // All three requesting at once drain in order 0, 1, 2
  task automatic testOrder();
    int cyc;
    doReset();
    setValids(3'b111);
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (!rv_if.valid && cyc < 20) begin
        step();
        cyc++;
      end
      checkOutput($sformatf("order%0d timeout", k), 32'(cyc >= 20), 0);
      checkOutput($sformatf("order%0d grant", k), 32'(grant), 32'(1 << k));
      rv_if.ready = 1'b1;
      rv_if.rdata = 32'h5000 + 32'(k);
      step();
      rv_if.ready = 1'b0;
      checkOutput($sformatf("order%0d ready", k), 32'(readyVec()), 32'(1 << k));
      applyStimulus(k, 1'b0, '0, '0, '0);
      step();
    end
  endtask

  // Continuous req1/req2 contention on both arbitration modes
  task automatic testContention();
    logic [2:0] rr_seen[$];
    logic [2:0] fp_seen[$];
    int cyc;
    doReset();
    setValids(3'b110);
    rv_if.ready = 1'b1;
    cyc = 0;
    while (rr_seen.size() < 4 && cyc < 60) begin
      step();
      cyc++;
      if (grant != 3'b000) rr_seen.push_back(grant);
      if (f_grant != 3'b000) fp_seen.push_back(f_grant);
    end
    checkOutput("rr count", 32'(rr_seen.size()), 4);
    checkOutput("fp count", 32'(fp_seen.size()), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr grant%0d", i), 32'(rr_seen[i]), (i % 2 == 0) ? 32'b010 : 32'b100);
      checkOutput($sformatf("fp grant%0d", i), 32'(fp_seen[i]), 32'b010);
    end
    setValids(3'b000);
    repeat (3) step();
    rv_if.ready = 1'b0;
    step();
  endtask

  // Late req0 write waits for the in-flight req1 access to finish
  task automatic testLateWrite();
    doReset();
    applyStimulus(1, 1'b1, reqAddr(1), reqData(1), 4'h0);
    step();
    checkOutput("late m1 grant", 32'(grant), 32'b010);
    applyStimulus(0, 1'b1, 23'h00_0840, 32'hCAFE_0000, 4'b0100);
    step();
    step();
    checkOutput("late hold grant", 32'(grant), 32'b010);
    checkOutput("late hold addr", 32'(rv_if.addr), 32'(reqAddr(1)));
    rv_if.ready = 1'b1;
    step();
    rv_if.ready = 1'b0;
    checkOutput("late m1 ready", 32'(readyVec()), 32'b010);
    applyStimulus(1, 1'b0, '0, '0, '0);
    step();
    checkOutput("late gap grant", 32'(grant), 0);
    step();
    checkOutput("late m0 grant", 32'(grant), 32'b001);
    checkOutput("late m0 wstrb", 32'(rv_if.wstrb), 32'b0100);
    checkOutput("late m0 wdata", rv_if.wdata, 32'hCAFE_0000);
    rv_if.ready = 1'b1;
    step();
    rv_if.ready = 1'b0;
    checkOutput("late m0 ready", 32'(readyVec()), 32'b001);
    applyStimulus(0, 1'b0, '0, '0, '0);
    step();
  endtask

  // Asynchronous reset in the middle of a transaction
  task automatic testMidReset();
    doReset();
    applyStimulus(1, 1'b1, reqAddr(1), reqData(1), 4'h0);
    step();
    checkOutput("midrst busy", 32'(rv_if.valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst rv_valid", 32'(rv_if.valid), 0);
    checkOutput("midrst grant", 32'(grant), 0);
    checkOutput("midrst ready", 32'(readyVec()), 0);
    applyStimulus(1, 1'b0, '0, '0, '0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    applyStimulus(2, 1'b1, reqAddr(2), reqData(2), 4'hF);
    step();
    checkOutput("midrst new grant", 32'(grant), 32'b100);
    checkOutput("midrst new addr", 32'(rv_if.addr), 32'(reqAddr(2)));
    rv_if.ready = 1'b1;
    rv_if.rdata = 32'h0000_600D;
    step();
    rv_if.ready = 1'b0;
    checkOutput("midrst new ready", 32'(readyVec()), 32'b100);
    checkOutput("midrst new rdata", m2_if.rdata, 32'h0000_600D);
    applyStimulus(2, 1'b0, '0, '0, '0);
    step();
  endtask

  // Randomized traffic against a transaction-level model of the arbiter
  task automatic testRandom();
    logic [2:0]    in_valid;
    logic          in_busy;
    logic          in_rvready;
    logic [31:0]   in_rvrdata;
    logic [AW-1:0] in_addr[3];
    logic [31:0]   in_wdata[3];
    logic [3:0]    in_wstrb[3];
    logic [2:0]    dut_ready;
    bit            m_inflight;
    bit            m_gap;
    bit            m_done_now;
    int            m_owner;
    int            m_last12;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_rdata[3];
    logic [2:0]    exp_grant;
    logic [2:0]    exp_ready;

    doReset();
    in_valid = '0;
    in_busy = 1'b0;
    in_rvready = 1'b0;
    in_rvrdata = '0;
    for (int n = 0; n < 3; n++) begin
      in_addr[n] = '0;
      in_wdata[n] = '0;
      in_wstrb[n] = '0;
      m_rdata[n] = '0;
    end
    m_inflight = 0;
    m_gap = 0;
    m_owner = 0;
    m_last12 = 2;
    m_addr = '0;
    m_wdata = '0;
    m_wstrb = '0;

    for (int t = 0; t < 3000; t++) begin
      step();
      // Advance the model by what the arbiter saw at this edge
      m_done_now = 0;
      if (!m_inflight && !m_gap) begin
        if (!in_busy && in_valid != 3'b000) begin
          if (in_valid[0]) m_owner = 0;
          else if (in_valid[1] && in_valid[2]) m_owner = (m_last12 == 1) ? 2 : 1;
          else if (in_valid[1]) m_owner = 1;
          else m_owner = 2;
          m_inflight = 1;
          m_addr = in_addr[m_owner];
          m_wdata = in_wdata[m_owner];
          m_wstrb = in_wstrb[m_owner];
        end
      end else if (m_inflight) begin
        if (in_rvready) begin
          m_inflight = 0;
          m_done_now = 1;
          m_gap = 1;
          m_rdata[m_owner] = in_rvrdata;
          if (m_owner != 0) m_last12 = m_owner;
        end
      end else begin
        m_gap = 0;
      end

      exp_grant = m_inflight ? 3'(1 << m_owner) : 3'b000;
      exp_ready = m_done_now ? 3'(1 << m_owner) : 3'b000;
      checkOutput($sformatf("rand t%0d grant", t), 32'(grant), 32'(exp_grant));
      checkOutput($sformatf("rand t%0d ready", t), 32'(readyVec()), 32'(exp_ready));
      checkOutput($sformatf("rand t%0d rv_valid", t), 32'(rv_if.valid), 32'(m_inflight));
      if (m_inflight) begin
        checkOutput($sformatf("rand t%0d rv_addr", t), 32'(rv_if.addr), 32'(m_addr));
        checkOutput($sformatf("rand t%0d rv_wdata", t), rv_if.wdata, m_wdata);
        checkOutput($sformatf("rand t%0d rv_wstrb", t), 32'(rv_if.wstrb), 32'(m_wstrb));
      end
      if (m_done_now) begin
        checkOutput($sformatf("rand t%0d rdata", t), rdataOf(m_owner), m_rdata[m_owner]);
      end

      // Requesters react to the ready they actually saw
      dut_ready = readyVec();
      for (int n = 0; n < 3; n++) begin
        if (dut_ready[n] || !in_valid[n]) begin
          in_valid[n] = (dut_ready[n] ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0));
          if (in_valid[n]) begin
            in_addr[n]  = AW'($urandom);
            in_wdata[n] = $urandom;
            in_wstrb[n] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
          end
        end
        applyStimulus(n, in_valid[n], in_addr[n], in_wdata[n], in_wstrb[n]);
      end
      if ($urandom_range(19) == 0) in_busy = ~in_busy;
      in_rvready = ($urandom_range(2) == 0);
      in_rvrdata = $urandom;
      ram_busy = in_busy;
      rv_if.ready = in_rvready;
      rv_if.rdata = in_rvrdata;
    end
  endtask

  initial begin
    vecs[0]  = '{3'b110, 1'b0, 32'h1111_0000, 3'b010};
    vecs[1]  = '{3'b110, 1'b0, 32'h1111_0001, 3'b100};
    vecs[2]  = '{3'b111, 1'b0, 32'h1111_0002, 3'b001};
    vecs[3]  = '{3'b110, 1'b0, 32'h1111_0003, 3'b010};
    vecs[4]  = '{3'b100, 1'b0, 32'h1111_0004, 3'b100};
    vecs[5]  = '{3'b100, 1'b0, 32'h1111_0005, 3'b100};
    vecs[6]  = '{3'b110, 1'b0, 32'h1111_0006, 3'b010};
    vecs[7]  = '{3'b010, 1'b0, 32'h1111_0007, 3'b010};
    vecs[8]  = '{3'b110, 1'b0, 32'h1111_0008, 3'b100};
    vecs[9]  = '{3'b101, 1'b0, 32'h1111_0009, 3'b001};
    vecs[10] = '{3'b011, 1'b0, 32'h1111_000A, 3'b001};
    vecs[11] = '{3'b111, 1'b1, 32'h1111_000B, 3'b000};

    $display("[TB] start");
    testReset();
    testTable();
    testRamBusy();
    testRead();
    testOrder();
    testContention();
    testLateWrite();
    testMidReset();
    testRandom();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop if the run ever wedges
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
